motoro3_commutator: RTL and testbench
=====================================

MOTORO3_COMMUTATOR -- requirements
Module: motoro3_commutator

Interface
REQ-001 Parameter PWM_W, default 8: width of the PWM counter, duty and period.
REQ-002 Parameter DEAD_CYC, default 10: dead-time cycles between steps (1 us at 10 MHz).
REQ-003 Parameter ALIGN_CYC, default 1000: rotor-align dwell in cycles.
REQ-004 Port clk, input, 1: 10 MHz clock; all logic SHALL sample on its rising edge.
REQ-005 Port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-006 Port start, input, 1: begin alignment from IDLE.
REQ-007 Port stop, input, 1: return to IDLE.
REQ-008 Port brake, input, 1: request low-side brake.
REQ-009 Port dir, input, 1: 1 = step increments, 0 = step decrements.
REQ-010 Port stepPulse, input, 1: single-cycle commutation request.
REQ-011 Port duty, input, PWM_W: PWM high count.
REQ-012 Port period, input, PWM_W: PWM counter terminal value.
REQ-013 Port pwm, output, 1: shared PWM to the three phase drivers.
REQ-014 Port mosEnable, output, 3: per-phase enable, bit0 = A, bit1 = B, bit2 = C.
REQ-015 Port h1_L0, output, 3: per-phase side select, 1 = high side, 0 = low side.
REQ-016 Port forceLow, output, 3: per-phase brake command.
REQ-017 Port step, output, 3: current commutation step, 0..5.
REQ-018 Port running, output, 1: high in ALIGN, RUN and DEAD.

Function
REQ-019 The PWM counter SHALL count 0..period and then wrap to 0.
REQ-020 pwm SHALL be registered as (cnt < dutyLatched).
REQ-021 dutyLatched SHALL load duty only in the cycle where cnt == period, so a duty change never produces a mid-period glitch.
REQ-022 duty > period SHALL give pwm constantly 1, and duty = 0 SHALL give pwm constantly 0.
REQ-023 With period = 0 the counter SHALL hold at 0 and pwm SHALL equal (dutyLatched != 0).
REQ-024 FSM states SHALL be IDLE, ALIGN, RUN, DEAD and BRAKE.
REQ-025 IDLE SHALL drive mosEnable=000 and forceLow=000, and start SHALL move the FSM to ALIGN with step=0.
REQ-026 ALIGN SHALL apply step 0 for ALIGN_CYC cycles and then enter RUN.
REQ-027 stepPulse SHALL be ignored in ALIGN.
REQ-028 In RUN, stepPulse SHALL enter DEAD with mosEnable=000 for exactly DEAD_CYC cycles.
REQ-029 On leaving DEAD, step SHALL become step+1 mod 6 (dir=1) or step-1 mod 6 (dir=0), with 5 wrapping to 0 and 0 wrapping to 5, and the FSM SHALL return to RUN.
REQ-030 stepPulse SHALL be ignored in DEAD, and dir SHALL be sampled on DEAD exit.
REQ-031 Step table (high/low, third phase floating): 0 A/B, 1 A/C, 2 B/C, 3 B/A, 4 C/A, 5 C/B.
REQ-032 The high phase SHALL have enable=1, h1_L0=1; the low phase enable=1, h1_L0=0; the floating phase enable=0.
REQ-033 Priority SHALL be stop > brake > stepPulse > start.
REQ-034 stop in any state SHALL force IDLE on the next edge.
REQ-035 All outputs SHALL be registered, updating one cycle after a state or step change.

Reset
REQ-036 rst SHALL set pwm=0, mosEnable=000, h1_L0=000, forceLow=000, step=0, running=0, cnt=0, dutyLatched=0, FSM=IDLE.
REQ-037 rst asserted mid-ALIGN, mid-RUN or mid-DEAD SHALL take effect on the next edge, with no partial dead-time retained.

Configuration
REQ-038 With MOTORO3_COMMUTATOR_BRAKE_EN defined, brake in any non-IDLE state SHALL enter BRAKE, driving mosEnable=111, forceLow=111 and h1_L0=000.
REQ-039 BRAKE SHALL exit to IDLE when brake deasserts, with stop still taking priority.
REQ-040 Without MOTORO3_COMMUTATOR_BRAKE_EN, the brake input SHALL be ignored, forceLow SHALL be tied to 000, and the BRAKE state SHALL be absent.

Structure
REQ-041 Package motoro3_pkg SHALL hold the FSM state enum, the six-entry step table (high-phase and low-phase indices), and the phase index constants.
REQ-042 Sub-module motoro3_pwm_gen SHALL contain the counter, duty latch and compare.
REQ-043 The FSM, dead-time counter and align counter SHALL reside in motoro3_commutator.

Verification
REQ-044 Scenario: rst, then start, with ALIGN_CYC=1000 -> running=1, step=0, mosEnable=011, h1_L0=001 for 1000 cycles, then RUN.
REQ-045 Scenario: period=99, duty=25 -> pwm high 25 of every 100 cycles; a duty change to 50 mid-period applies only from the next wrap.
REQ-046 Scenario: in RUN at step=5 with dir=1, pulse stepPulse -> mosEnable=000 for 10 cycles, then step=0, mosEnable=011; with dir=0 from step=0 -> step=5, mosEnable=110, h1_L0=100.
REQ-047 Scenario: stepPulse repeated during DEAD -> exactly one step advance.
REQ-048 Scenario: brake (macro on) during RUN -> next cycle mosEnable=111, forceLow=111; brake with stop in the same cycle -> IDLE; macro off -> brake has no effect.
REQ-049 Scenario: rst in DEAD cycle 4 -> all outputs 0 next cycle, FSM=IDLE; duty=0 -> pwm constantly 0; duty=255 with period=100 -> pwm constantly 1.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared types and the commutation step table for the motoro3 three-phase commutator.
// MOTORO3_COMMUTATOR_BRAKE_EN adds the BRAKE state to the FSM enum.
package motoro3_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_RUN,
      ST_DEAD
`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
      , ST_BRAKE
`endif
   } state_t;

   localparam logic [1:0] PH_A = 2'd0;
   localparam logic [1:0] PH_B = 2'd1;
   localparam logic [1:0] PH_C = 2'd2;

   // Indexed by step 0..5 (rightmost entry is step 0); the third phase floats.
   localparam logic [5:0][1:0] STEP_HI = {PH_C, PH_C, PH_B, PH_B, PH_A, PH_A};
   localparam logic [5:0][1:0] STEP_LO = {PH_B, PH_A, PH_A, PH_C, PH_C, PH_B};

   function automatic logic [2:0] step_next(input logic [2:0] s, input logic d);
      if (d) return (s == 3'd5) ? 3'd0 : s + 3'd1;
      else   return (s == 3'd0) ? 3'd5 : s - 3'd1;
   endfunction

   function automatic logic [2:0] phase_bit(input logic [1:0] ph);
      return 3'b001 << ph;
   endfunction

endpackage

// File: rtl/motoro3_pwm_gen.sv
// Free-running PWM: counter 0..period, duty latched at wrap so a duty change never
// glitches the current period.
module motoro3_pwm_gen
   import motoro3_pkg::*;
#(
   parameter int PWM_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [PWM_W-1:0] i_duty,
   input  logic [PWM_W-1:0] i_period,
   output logic             o_pwm
);

   logic [PWM_W-1:0] r_cnt;
   logic [PWM_W-1:0] r_duty_lat;
   logic             r_pwm;
   logic             w_wrap;

   // >= also recovers cleanly when period is lowered below the running count
   assign w_wrap = (r_cnt >= i_period);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_duty_lat <= '0;
         r_pwm      <= 1'b0;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + PWM_W'(1);
         if (w_wrap) r_duty_lat <= i_duty;
         r_pwm <= (r_cnt < r_duty_lat);
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/motoro3_commutator.sv
// Six-step BLDC commutator: align dwell, dead-time between steps, optional low-side brake
// (enabled by MOTORO3_COMMUTATOR_BRAKE_EN). Outputs are registered from the current state.
//
//   state    | meaning
//   ST_IDLE  | all drivers off, waiting for start
//   ST_ALIGN | step 0 applied for ALIGN_CYC cycles to park the rotor
//   ST_RUN   | current step applied, waiting for stepPulse
//   ST_DEAD  | all drivers off for DEAD_CYC cycles, then step advances
//   ST_BRAKE | all low sides on (brake build only)
module motoro3_commutator
   import motoro3_pkg::*;
#(
   parameter int PWM_W     = 8,
   parameter int DEAD_CYC  = 10,
   parameter int ALIGN_CYC = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             brake,
   input  logic             dir,
   input  logic             stepPulse,
   input  logic [PWM_W-1:0] duty,
   input  logic [PWM_W-1:0] period,
   output logic             pwm,
   output logic [2:0]       mosEnable,
   output logic [2:0]       h1_L0,
   output logic [2:0]       forceLow,
   output logic [2:0]       step,
   output logic             running
);

   localparam int TMR_MAX = (ALIGN_CYC > DEAD_CYC) ? ALIGN_CYC : DEAD_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t           r_state;
   logic [2:0]       r_step;
   logic [TMR_W-1:0] r_tmr;
   logic [2:0]       r_mos;
   logic [2:0]       r_h1;
   logic [2:0]       r_step_o;
   logic             r_run;

   motoro3_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_duty   (duty),
      .i_period (period),
      .o_pwm    (pwm)
   );

`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
   logic [2:0] r_force;
   assign forceLow = r_force;
`else
   logic w_unused_brake;
   assign w_unused_brake = brake;
   assign forceLow       = 3'b000;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_step   <= 3'd0;
         r_tmr    <= '0;
         r_mos    <= 3'b000;
         r_h1     <= 3'b000;
         r_step_o <= 3'd0;
         r_run    <= 1'b0;
`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
         r_force  <= 3'b000;
`endif
      end else begin
         // output decode of the state/step held before this edge
         r_step_o <= r_step;
         r_mos    <= 3'b000;
         r_h1     <= 3'b000;
         r_run    <= 1'b0;
`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
         r_force  <= 3'b000;
`endif
         case (r_state)
            ST_ALIGN, ST_RUN: begin
               r_mos <= phase_bit(STEP_HI[r_step]) | phase_bit(STEP_LO[r_step]);
               r_h1  <= phase_bit(STEP_HI[r_step]);
               r_run <= 1'b1;
            end
            ST_DEAD: r_run <= 1'b1;
`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
            ST_BRAKE: begin
               r_mos   <= 3'b111;
               r_force <= 3'b111;
            end
`endif
            default: ;
         endcase

         if (stop) begin
            r_state <= ST_IDLE;
`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
         end else if (brake && (r_state != ST_IDLE)) begin
            r_state <= ST_BRAKE;
`endif
         end else begin
            case (r_state)
               ST_IDLE: if (start) begin
                  r_state <= ST_ALIGN;
                  r_step  <= 3'd0;
                  r_tmr   <= TMR_W'(ALIGN_CYC - 1);
               end
               ST_ALIGN: begin
                  if (r_tmr == '0) r_state <= ST_RUN;
                  else             r_tmr   <= r_tmr - TMR_W'(1);
               end
               ST_RUN: if (stepPulse) begin
                  r_state <= ST_DEAD;
                  r_tmr   <= TMR_W'(DEAD_CYC - 1);
               end
               ST_DEAD: begin
                  if (r_tmr == '0) begin
                     r_state <= ST_RUN;
                     r_step  <= step_next(r_step, dir);
                  end else begin
                     r_tmr <= r_tmr - TMR_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign mosEnable = r_mos;
   assign h1_L0     = r_h1;
   assign step      = r_step_o;
   assign running   = r_run;

endmodule

// File: tb/tb_motoro3_commutator.sv
// Self-checking bench for motoro3_commutator: cycle model compared every cycle plus
// directed literal checks of align, dead-time, step wrap, PWM duty and reset behaviour.
module tb_motoro3_commutator;

   localparam int PWM_W     = 8;
   localparam int DEAD_CYC  = 10;
   localparam int ALIGN_CYC = 1000;
`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
   localparam bit BRAKE_EN = 1'b1;
`else
   localparam bit BRAKE_EN = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_ALIGN = 1;
   localparam int M_RUN   = 2;
   localparam int M_DEAD  = 3;
   localparam int M_BRAKE = 4;

   // enables and high sides straight from the step table: 0 A/B, 1 A/C, 2 B/C, 3 B/A, 4 C/A, 5 C/B
   localparam logic [2:0] T_MOS [6] = '{3'b011, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110};
   localparam logic [2:0] T_H1  [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

   logic             clk = 1'b0;
   logic             rst, start, stop, brake, dir, stepPulse;
   logic [PWM_W-1:0] duty, period;
   logic             pwm;
   logic [2:0]       mosEnable, h1_L0, forceLow, step;
   logic             running;

   always #50 clk = ~clk;

   motoro3_commutator #(.PWM_W(PWM_W), .DEAD_CYC(DEAD_CYC), .ALIGN_CYC(ALIGN_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .brake     (brake),
      .dir       (dir),
      .stepPulse (stepPulse),
      .duty      (duty),
      .period    (period),
      .pwm       (pwm),
      .mosEnable (mosEnable),
      .h1_L0     (h1_L0),
      .forceLow  (forceLow),
      .step      (step),
      .running   (running)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_cyc = 0;
   int         m_mode, m_step, m_until, m_pos, m_lat;
   logic       e_pwm, e_run;
   logic [2:0] e_mos, e_h1, e_force, e_step;
   bit         check_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = M_IDLE; m_step = 0; m_until = 0; m_pos = 0; m_lat = 0;
         e_pwm = 1'b0; e_run = 1'b0; e_mos = 3'b000; e_h1 = 3'b000;
         e_force = 3'b000; e_step = 3'd0;
      end else begin
         // outputs show what the machine was doing during the cycle that just ended
         e_step  = 3'(m_step);
         e_run   = (m_mode == M_ALIGN) || (m_mode == M_RUN) || (m_mode == M_DEAD);
         e_mos   = (m_mode == M_ALIGN || m_mode == M_RUN) ? T_MOS[m_step] :
                   (m_mode == M_BRAKE) ? 3'b111 : 3'b000;
         e_h1    = (m_mode == M_ALIGN || m_mode == M_RUN) ? T_H1[m_step] : 3'b000;
         e_force = (m_mode == M_BRAKE) ? 3'b111 : 3'b000;

         if (stop) m_mode = M_IDLE;
         else if (BRAKE_EN && brake && m_mode != M_IDLE) m_mode = M_BRAKE;
         else begin
            case (m_mode)
               M_IDLE:  if (start) begin m_mode = M_ALIGN; m_step = 0; m_until = m_cyc + ALIGN_CYC; end
               M_ALIGN: if (m_cyc >= m_until) m_mode = M_RUN;
               M_RUN:   if (stepPulse) begin m_mode = M_DEAD; m_until = m_cyc + DEAD_CYC; end
               M_DEAD:  if (m_cyc >= m_until) begin
                           m_mode = M_RUN;
                           m_step = dir ? (m_step + 1) % 6 : (m_step + 5) % 6;
                        end
               M_BRAKE: m_mode = M_IDLE;
               default: m_mode = M_IDLE;
            endcase
         end

         e_pwm = (m_pos < m_lat);
         if (m_pos >= int'(period)) begin m_pos = 0; m_lat = int'(duty); end
         else m_pos++;
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("m_pwm",       32'(pwm),       32'(e_pwm));
         chk("m_mosEnable", 32'(mosEnable), 32'(e_mos));
         chk("m_h1_L0",     32'(h1_L0),     32'(e_h1));
         chk("m_forceLow",  32'(forceLow),  32'(e_force));
         chk("m_step",      32'(step),      32'(e_step));
         chk("m_running",   32'(running),   32'(e_run));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic pulse_step(input logic d, output int n_dead);
      dir = d; stepPulse = 1'b1;
      @(negedge clk);
      stepPulse = 1'b0;
      n_dead = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mosEnable == 3'b000) n_dead++;
      end
   endtask

   task automatic count_pwm(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (pwm) hi++;
      end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int   nd, hi;
      logic prev;
      bit   found;

      rst = 1'b1; start = 1'b0; stop = 1'b0; brake = 1'b0; dir = 1'b1; stepPulse = 1'b0;
      duty = 8'd25; period = 8'd99;
      @(negedge clk);
      check_en = 1'b1;
      chk("rst_mos",     32'(mosEnable), 32'h0);
      chk("rst_h1",      32'(h1_L0),     32'h0);
      chk("rst_force",   32'(forceLow),  32'h0);
      chk("rst_step",    32'(step),      32'h0);
      chk("rst_running", 32'(running),   32'h0);
      chk("rst_pwm",     32'(pwm),       32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // start -> align on step 0
      start = 1'b1; @(negedge clk); start = 1'b0;
      @(negedge clk);
      chk("align_running", 32'(running),   32'h1);
      chk("align_mos",     32'(mosEnable), 32'h3);
      chk("align_h1",      32'(h1_L0),     32'h1);
      chk("align_step",    32'(step),      32'h0);
      repeat (ALIGN_CYC - 2) @(negedge clk);
      chk("align_last_mos", 32'(mosEnable), 32'h3);
      stepPulse = 1'b1; @(negedge clk); stepPulse = 1'b0;
      repeat (5) @(negedge clk);
      chk("align_pulse_ignored_mos", 32'(mosEnable), 32'h3);
      chk("align_pulse_ignored_run", 32'(running),   32'h1);

      // dir=0 from step 0 wraps to 5, dir=1 from 5 wraps to 0
      pulse_step(1'b0, nd);
      chk("dead_len_down", 32'(nd),        32'd10);
      chk("wrap_down_step", 32'(step),     32'd5);
      chk("wrap_down_mos", 32'(mosEnable), 32'h6);
      chk("wrap_down_h1",  32'(h1_L0),     32'h4);
      pulse_step(1'b1, nd);
      chk("dead_len_up",   32'(nd),        32'd10);
      chk("wrap_up_step",  32'(step),      32'd0);
      chk("wrap_up_mos",   32'(mosEnable), 32'h3);
      chk("wrap_up_h1",    32'(h1_L0),     32'h1);

      // repeated pulses in DEAD give one advance; dir taken at DEAD exit
      dir = 1'b0; stepPulse = 1'b1; @(negedge clk);
      stepPulse = 1'b0; @(negedge clk);
      stepPulse = 1'b1; @(negedge clk);
      stepPulse = 1'b0; dir = 1'b1; @(negedge clk);
      stepPulse = 1'b1; @(negedge clk);
      stepPulse = 1'b0;
      repeat (20) @(negedge clk);
      chk("one_advance_step", 32'(step),      32'd1);
      chk("one_advance_mos",  32'(mosEnable), 32'h5);
      chk("one_advance_h1",   32'(h1_L0),     32'h1);

      // PWM duty and glitch-free duty update
      count_pwm(100, hi);
      chk("pwm_duty25", 32'(hi), 32'd25);
      found = 1'b0;
      prev  = pwm;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pwm && !prev) begin found = 1'b1; break; end
         prev = pwm;
      end
      chk("pwm_edge_found", 32'(found), 32'h1);
      duty = 8'd50;
      count_pwm(99, hi);
      chk("pwm_old_duty_kept", 32'(hi + 1), 32'd25);
      count_pwm(100, hi);
      chk("pwm_duty50", 32'(hi), 32'd50);
      duty = 8'd0;
      repeat (150) @(negedge clk);
      count_pwm(200, hi);
      chk("pwm_duty0", 32'(hi), 32'd0);
      duty = 8'd255; period = 8'd100;
      repeat (150) @(negedge clk);
      count_pwm(202, hi);
      chk("pwm_duty_gt_period", 32'(hi), 32'd202);
      period = 8'd0; duty = 8'd3;
      repeat (5) @(negedge clk);
      count_pwm(20, hi);
      chk("pwm_period0_duty3", 32'(hi), 32'd20);
      duty = 8'd0;
      repeat (3) @(negedge clk);
      count_pwm(20, hi);
      chk("pwm_period0_duty0", 32'(hi), 32'd0);
      period = 8'd99; duty = 8'd25;

`ifdef MOTORO3_COMMUTATOR_BRAKE_EN
      brake = 1'b1; @(negedge clk); @(negedge clk);
      chk("brake_mos",   32'(mosEnable), 32'h7);
      chk("brake_force", 32'(forceLow),  32'h7);
      chk("brake_h1",    32'(h1_L0),     32'h0);
      brake = 1'b0;
      repeat (2) @(negedge clk);
      chk("brake_exit_mos", 32'(mosEnable), 32'h0);
      chk("brake_exit_run", 32'(running),   32'h0);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      stop = 1'b1; brake = 1'b1; @(negedge clk);
      stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("stop_over_brake_mos",   32'(mosEnable), 32'h0);
      chk("stop_over_brake_force", 32'(forceLow),  32'h0);
      brake = 1'b0;
`else
      brake = 1'b1;
      repeat (5) @(negedge clk);
      chk("brake_off_mos",   32'(mosEnable), 32'h5);
      chk("brake_off_force", 32'(forceLow),  32'h0);
      chk("brake_off_run",   32'(running),   32'h1);
      brake = 1'b0;
`endif

      // back to RUN, then reset in DEAD cycle 4
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (ALIGN_CYC + 3) @(negedge clk);
      chk("rerun_mos", 32'(mosEnable), 32'h3);
      stepPulse = 1'b1; @(negedge clk); stepPulse = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1; @(negedge clk);
      chk("dead_rst_mos",   32'(mosEnable), 32'h0);
      chk("dead_rst_h1",    32'(h1_L0),     32'h0);
      chk("dead_rst_force", 32'(forceLow),  32'h0);
      chk("dead_rst_step",  32'(step),      32'h0);
      chk("dead_rst_run",   32'(running),   32'h0);
      chk("dead_rst_pwm",   32'(pwm),       32'h0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("post_rst_idle_mos", 32'(mosEnable), 32'h0);
      chk("post_rst_idle_run", 32'(running),   32'h0);
      chk("post_rst_step",     32'(step),      32'h0);

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
